// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution unit: op codes, compare codes, PC step.
package branch_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CMP_W  = 2;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [OP_W-1:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BGE  = 3'd3,
    OP_BLTU = 3'd4,
    OP_BGEU = 3'd5,
    OP_BLTZ = 3'd6,
    OP_BGTZ = 3'd7
  } op_e;

  typedef enum logic [CMP_W-1:0] {
    CMP_DEFAULT = 2'b00,
    CMP_EQUAL   = 2'b01,
    CMP_LT      = 2'b10,
    CMP_GT      = 2'b11
  } cmp_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: direction plus three-way compare code.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [OP_W-1:0]   op,
  output logic              taken,
  output logic [CMP_W-1:0]  cmp
);

  logic [DATA_W-1:0] rt_eff;
  logic              is_signed;
  logic              eq;
  logic              lt;

  // Select operand/signedness per op, then compare and decode the direction
  always_comb begin
    rt_eff    = rt;
    is_signed = 1'b1;
    taken     = 1'b0;
    cmp       = CMP_DEFAULT;

    case (op_e'(op))
      OP_BLTZ, OP_BGTZ: rt_eff    = '0;
      OP_BLTU, OP_BGEU: is_signed = 1'b0;
      default:          rt_eff    = rt;
    endcase

    eq = (rs == rt_eff);
    lt = is_signed ? ($signed(rs) < $signed(rt_eff)) : (rs < rt_eff);

    case (op_e'(op))
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BLTU: taken = lt;
      OP_BGEU: taken = !lt;
      OP_BLTZ: taken = lt;
      OP_BGTZ: taken = !lt && !eq;
      default: taken = 1'b0;
    endcase

    case (op_e'(op))
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_BLTZ, OP_BGTZ:
        cmp = eq ? CMP_EQUAL : (lt ? CMP_LT : CMP_GT);
      default:
        cmp = CMP_DEFAULT;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Two-stage pipelined branch resolution: S1 holds the request and compares,
// S2 holds the registered redirect/mispredict result.
// Optional macro BRANCH_RESOLVE_STATS_EN builds saturating branch/mispredict counters;
// otherwise the stat ports are tied to zero.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_imm,
  input  logic              in_pred_taken,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [CMP_W-1:0]  out_cmp,
  output logic              out_mispredict,
  output logic [PC_W-1:0]   out_redirect_pc,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_rs;
  logic [DATA_W-1:0] s1_rt;
  logic [PC_W-1:0]   s1_pc;
  logic [PC_W-1:0]   s1_imm;
  logic              s1_pred;
  logic              s1_taken;
  logic [CMP_W-1:0]  s1_cmp;
  logic [PC_W-1:0]   s1_fall;
  logic [PC_W-1:0]   s1_target;
  logic              s2_load;

  // Handshake: S2 refills when empty or drained; S1 follows S2
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_load);

  // Both next-PC candidates wrap modulo 2^PC_W
  assign s1_fall   = s1_pc + PC_W'(PC_INC);
  assign s1_target = s1_fall + (s1_imm << 2);

  branch_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .rs    (s1_rs),
    .rt    (s1_rt),
    .op    (s1_op),
    .taken (s1_taken),
    .cmp   (s1_cmp)
  );

  // S1: capture accepted requests; hold while S2 is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_rs    <= '0;
      s1_rt    <= '0;
      s1_pc    <= '0;
      s1_imm   <= '0;
      s1_pred  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= in_op;
        s1_rs   <= in_rs;
        s1_rt   <= in_rt;
        s1_pc   <= in_pc;
        s1_imm  <= in_imm;
        s1_pred <= in_pred_taken;
      end
    end
  end

  // S2: register the resolved result; frozen under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_cmp         <= CMP_DEFAULT;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_cmp        <= CMP_DEFAULT;
      out_mispredict <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_taken       <= s1_taken;
        out_cmp         <= s1_cmp;
        out_mispredict  <= s1_taken ^ s1_pred;
        out_redirect_pc <= s1_taken ? s1_target : s1_fall;
      end else begin
        out_taken      <= 1'b0;
        out_cmp        <= CMP_DEFAULT;
        out_mispredict <= 1'b0;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic out_fire;
  assign out_fire = out_valid && out_ready && !flush;

  // Saturating performance counters on completed output handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (out_fire) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (out_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
